ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
// - Shares the single-port data ram between two masters: port 0 = cpu data port, port 1 = debug/loader port.
// - One access per cycle to ram; round-robin with lock and hold limit; read data returned with 1-cycle latency.
// - Sits between cpu mem_* outputs and ram wr_sig/wr_data/addr/rd_data inputs.
// PARAMETERS
// - ADDR_W    32  address width
// - DATA_W    32  data width
// - MAX_HOLD  4   max consecutive grants to one locked master while the other requests (1..15)
// PORTS
// - clk          in   1       clock, all logic on rising edge
// - reset        in   1       synchronous, active-high reset
// - m0_req/m1_req in  1       access request, held until granted
// - m0_we/m1_we   in  1       1 = write, 0 = read
// - m0_lock/m1_lock in 1      keep ownership across consecutive requests
// - m0_addr/m1_addr in ADDR_W byte address
// - m0_wdata/m1_wdata in DATA_W write data
// - m0_gnt/m1_gnt out 1       access accepted this cycle (combinational)
// - m0_rvalid/m1_rvalid out 1 read data valid (cycle after read grant)
// - m0_rdata/m1_rdata out DATA_W read data, valid with rvalid, else 0
// - ram_wr_sig   out  1       ram write strobe
// - ram_addr     out  ADDR_W  ram address
// - ram_wr_data  out  DATA_W  ram write data
// - ram_rd_data  in   DATA_W  ram read data (registered ram, 1-cycle latency)
// BEHAVIOUR
// - FSM states: IDLE (no owner), OWN0, OWN1. State, last_winner, hold_cnt, rd_pend, rd_owner are registers.
// - IDLE: single req -> grant it; both req -> grant !last_winner (round-robin). Granted master with lock=1 -> OWNx.
// - OWNx: master x granted whenever it requests; other master blocked. Leave to IDLE when x drops lock or req.
// - Hold limit: in OWNx, hold_cnt increments per grant to x while other master requests; at MAX_HOLD the next
//   cycle grants the other master, hold_cnt clears, state -> IDLE (or OWNy if y locks). hold_cnt clears when other idle.
// - At most one gnt high per cycle; gnt implies ram access that cycle: ram_* = granted master's signals,
//   ram_wr_sig = gnt & we. No grant -> ram_wr_sig=0, ram_addr=0, ram_wr_data=0.
// - Read grant at cycle N -> rvalid to that master at N+1, rdata = ram_rd_data; other master's rdata = 0.
// - Back-to-back reads (either master) sustain 1 access/cycle; write grants produce no rvalid.
// - last_winner updates on every grant. Reset: state=IDLE, last_winner=1 (m0 wins first tie), hold_cnt=0,
//   rd_pend=0; all gnt/rvalid/rdata/ram_* outputs 0 in and after the reset cycle.
// - Reset mid-operation: pending read is dropped (no rvalid), lock ownership released.
// - req deasserted while not granted: nothing happens; no request queuing inside the block.
// CONFIGURATION
// - RAM_ARB_STATS_EN defined: adds outputs stat_gnt0, stat_gnt1 (32b grant counts) and stat_conflict
//   (32b count of cycles with both req high); saturate at all-ones; cleared by reset.
// - Not defined: ports and counters absent; arbitration identical.
// PACKAGE / STRUCTURE
// - Shared parameters.vh: state encodings ARB_IDLE=2'd0, ARB_OWN0=2'd1, ARB_OWN1=2'd2; MAX_HOLD default.
// - One sub-module: arb_rr2 (combinational 2-way round-robin pick from req + last_winner + owner state).
// - Top holds FSM, hold counter, read-return register, ram mux, optional stats.
// TESTING
// - Single master: m0 read 0x10 (ram holds 0xDEADBEEF) -> m0_gnt same cycle, m0_rvalid next cycle, rdata=0xDEADBEEF.
// - Tie after reset: both req, no lock -> m0 granted, then m1, then m0 alternately, one gnt per cycle.
// - Lock + hold limit: m0 lock=1 streaming, m1 req=1 -> m0 gets exactly 4 grants, then m1 granted once.
// - Write then read: m1 writes 0x1234 to 0x20, m0 reads 0x20 next cycle -> m0_rdata=0x1234, m1_rvalid stays 0.
// - Reset mid-read: read granted at N, reset at N+1 -> no rvalid, all outputs 0, state IDLE afterwards.
// - RAM_ARB_STATS_EN: 10 cycles both req -> stat_conflict=10, stat_gnt0+stat_gnt1=10.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and constants for the ram arbiter
// Purpose: arbiter FSM state encoding, default hold limit, counter widths and
//          a saturating increment used by the optional statistics counters.
// Ports:   none (package).
package ram_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;

   localparam int MAX_HOLD_DEFAULT = 4;
   localparam int HOLD_W           = 4;   // holds MAX_HOLD up to 15
   localparam int STAT_W           = 32;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/ram_arbiter_arb_rr2.sv
// rtl/ram_arbiter_arb_rr2.sv - combinational two-way round-robin pick
// Purpose: chooses which master may access the ram this cycle from the
//          requests, the previous winner and the current ownership state.
// Ports:   req0/req1    request from master 0/1
//          last_winner  master granted most recently (1 = master 1)
//          hold_full    owner has used up its consecutive-grant allowance
//          state        current ownership state (IDLE / OWN0 / OWN1)
//          gnt0/gnt1    one-hot (or zero) pick
module arb_rr2
   import ram_arbiter_pkg::*;
(
   input  logic       req0,
   input  logic       req1,
   input  logic       last_winner,
   input  logic       hold_full,
   input  arb_state_t state,
   output logic       gnt0,
   output logic       gnt1
);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state)
         ARB_IDLE: begin
            // On a tie the master that did not win last time goes first.
            gnt0 = req0 & (~req1 | last_winner);
            gnt1 = req1 & (~req0 | ~last_winner);
         end
         ARB_OWN0: begin
            if (hold_full & req1) gnt1 = 1'b1;
            else                  gnt0 = req0;
         end
         ARB_OWN1: begin
            if (hold_full & req0) gnt0 = 1'b1;
            else                  gnt1 = req1;
         end
         default: begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares the single-port data ram between cpu and debug ports
// Purpose: one ram access per cycle, round-robin with lock and a hold limit,
//          read data returned one cycle after the read grant.
//          Optional statistics counters are built when RAM_ARB_STATS_EN is defined.
// Ports:   clk, reset (synchronous, active-high)
//          m0_* cpu data port, m1_* debug/loader port:
//             req, we, lock, addr, wdata in; gnt (combinational), rvalid, rdata out
//          ram_wr_sig, ram_addr, ram_wr_data to the ram; ram_rd_data from the ram
//          stat_gnt0, stat_gnt1, stat_conflict (RAM_ARB_STATS_EN only)
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = MAX_HOLD_DEFAULT
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              ram_wr_sig,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   input  logic [DATA_W-1:0] ram_rd_data
`ifdef RAM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_gnt0,
   output logic [STAT_W-1:0] stat_gnt1,
   output logic [STAT_W-1:0] stat_conflict
`endif
);

   localparam logic [HOLD_W-1:0] MAX_HOLD_V = HOLD_W'(MAX_HOLD);

   arb_state_t        state, state_nxt;
   logic              last_winner;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic              rd_pend, rd_owner;
   logic              pick0, pick1;
   logic              hold_full;

   assign hold_full = (hold_cnt >= MAX_HOLD_V);

   arb_rr2 u_arb (
      .req0        (m0_req),
      .req1        (m1_req),
      .last_winner (last_winner),
      .hold_full   (hold_full),
      .state       (state),
      .gnt0        (pick0),
      .gnt1        (pick1)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ARB_IDLE;
      else       state <= state_nxt;
   end

   // Next state and hold count. Ownership survives only while the winner
   // keeps lock asserted; the count only runs while the other side waits.
   always_comb begin
      state_nxt = ARB_IDLE;
      hold_nxt  = '0;
      if (pick0) begin
         if (m0_lock) begin
            state_nxt = ARB_OWN0;
            if (m1_req) hold_nxt = (state == ARB_OWN0) ? hold_cnt + HOLD_W'(1) : HOLD_W'(1);
         end
      end else if (pick1) begin
         if (m1_lock) begin
            state_nxt = ARB_OWN1;
            if (m0_req) hold_nxt = (state == ARB_OWN1) ? hold_cnt + HOLD_W'(1) : HOLD_W'(1);
         end
      end
   end

   // Outputs. Everything is forced quiet while reset is asserted.
   always_comb begin
      m0_gnt      = pick0 & ~reset;
      m1_gnt      = pick1 & ~reset;
      ram_wr_sig  = 1'b0;
      ram_addr    = '0;
      ram_wr_data = '0;
      if (m0_gnt) begin
         ram_wr_sig  = m0_we;
         ram_addr    = m0_addr;
         ram_wr_data = m0_wdata;
      end else if (m1_gnt) begin
         ram_wr_sig  = m1_we;
         ram_addr    = m1_addr;
         ram_wr_data = m1_wdata;
      end
      m0_rvalid = ~reset & rd_pend & ~rd_owner;
      m1_rvalid = ~reset & rd_pend & rd_owner;
      m0_rdata  = m0_rvalid ? ram_rd_data : '0;
      m1_rdata  = m1_rvalid ? ram_rd_data : '0;
   end

   // Round-robin memory, hold counter and the read-return tag.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_winner <= 1'b1;
         hold_cnt    <= '0;
         rd_pend     <= 1'b0;
         rd_owner    <= 1'b0;
      end else begin
         if (pick0 | pick1) last_winner <= pick1;
         hold_cnt <= hold_nxt;
         rd_pend  <= (pick0 & ~m0_we) | (pick1 & ~m1_we);
         rd_owner <= pick1;
      end
   end

`ifdef RAM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_gnt0     <= '0;
         stat_gnt1     <= '0;
         stat_conflict <= '0;
      end else begin
         if (m0_gnt)          stat_gnt0     <= sat_inc(stat_gnt0);
         if (m1_gnt)          stat_gnt1     <= sat_inc(stat_gnt1);
         if (m0_req & m1_req) stat_conflict <= sat_inc(stat_conflict);
      end
   end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;

   localparam int MAX_HOLD = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        mem_init;
   logic        req [2];
   logic        we [2];
   logic        lock [2];
   logic [31:0] addr [2];
   logic [31:0] wdata [2];

   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_wr_sig;
   logic [31:0] ram_addr, ram_wr_data, ram_rd_data;
`ifdef RAM_ARB_STATS_EN
   logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

   ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
      .clk         (clk),
      .reset       (reset),
      .m0_req      (req[0]),
      .m0_we       (we[0]),
      .m0_lock     (lock[0]),
      .m0_addr     (addr[0]),
      .m0_wdata    (wdata[0]),
      .m0_gnt      (m0_gnt),
      .m0_rvalid   (m0_rvalid),
      .m0_rdata    (m0_rdata),
      .m1_req      (req[1]),
      .m1_we       (we[1]),
      .m1_lock     (lock[1]),
      .m1_addr     (addr[1]),
      .m1_wdata    (wdata[1]),
      .m1_gnt      (m1_gnt),
      .m1_rvalid   (m1_rvalid),
      .m1_rdata    (m1_rdata),
      .ram_wr_sig  (ram_wr_sig),
      .ram_addr    (ram_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_data (ram_rd_data)
`ifdef RAM_ARB_STATS_EN
      ,
      .stat_gnt0     (stat_gnt0),
      .stat_gnt1     (stat_gnt1),
      .stat_conflict (stat_conflict)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_val(input int i);
      return (i == 4) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(i));
   endfunction

   // Registered single-port ram seen by the DUT.
   logic [31:0] ram_mem [64];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) ram_mem[i] <= init_val(i);
      end else if (ram_wr_sig) begin
         ram_mem[ram_addr[7:2]] <= ram_wr_data;
      end
      ram_rd_data <= ram_mem[ram_addr[7:2]];
   end

   // Behavioural model: who owns the ram, how long the owner has kept the
   // other side waiting, who won last, and the read owed next cycle.
   logic [31:0] exp_mem [64];
   int          own    = -1;
   int          streak = 0;
   int          lastw  = 1;
   bit          pv     = 1'b0;
   int          pw     = 0;
   logic [31:0] pd     = '0;
   int          obs_g;
   logic        obs_rv [2];
   logic [31:0] obs_rd [2];

   initial begin
      for (int i = 0; i < 64; i++) exp_mem[i] = init_val(i);
   end

   always @(negedge clk) begin
      int eg;
      if (reset) eg = -1;
      else if (own >= 0) begin
         if (req[1-own] && streak >= MAX_HOLD) eg = 1 - own;
         else if (req[own])                    eg = own;
         else                                  eg = -1;
      end
      else if (req[0] && req[1]) eg = (lastw == 1) ? 0 : 1;
      else if (req[0])           eg = 0;
      else if (req[1])           eg = 1;
      else                       eg = -1;

      chk("m0_gnt", 32'(m0_gnt), 32'(eg == 0));
      chk("m1_gnt", 32'(m1_gnt), 32'(eg == 1));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(!reset && pv && pw == 0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(!reset && pv && pw == 1));
      chk("m0_rdata", m0_rdata, (!reset && pv && pw == 0) ? pd : 32'h0);
      chk("m1_rdata", m1_rdata, (!reset && pv && pw == 1) ? pd : 32'h0);
      chk("ram_wr_sig", 32'(ram_wr_sig), (eg >= 0) ? 32'(we[eg]) : 32'h0);
      chk("ram_addr", ram_addr, (eg >= 0) ? addr[eg] : 32'h0);
      chk("ram_wr_data", ram_wr_data, (eg >= 0) ? wdata[eg] : 32'h0);

      obs_g     = m0_gnt ? (m1_gnt ? 2 : 0) : (m1_gnt ? 1 : -1);
      obs_rv[0] = m0_rvalid;
      obs_rv[1] = m1_rvalid;
      obs_rd[0] = m0_rdata;
      obs_rd[1] = m1_rdata;

      if (reset) begin
         own = -1; streak = 0; lastw = 1; pv = 1'b0;
      end else begin
         pv = (eg >= 0) && !we[eg];
         if (eg >= 0) begin
            pw = eg;
            if (!we[eg]) pd = exp_mem[addr[eg][7:2]];
            else         exp_mem[addr[eg][7:2]] = wdata[eg];
            if (lock[eg] && req[1-eg]) streak = (own == eg) ? streak + 1 : 1;
            else                       streak = 0;
            own   = lock[eg] ? eg : -1;
            lastw = eg;
         end else begin
            own = -1; streak = 0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int m, input logic r, input logic w, input logic l,
                        input logic [31:0] a, input logic [31:0] d);
      req[m] = r; we[m] = w; lock[m] = l; addr[m] = a; wdata[m] = d;
   endtask

   task automatic idle_all();
      set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_all();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tie_exp  [4] = '{0, 1, 0, 1};
      int lock_exp [6] = '{0, 0, 0, 0, 1, 0};
      int n;

      // Reset: a request during reset must not be granted.
      reset = 1'b1; mem_init = 1'b1;
      idle_all();
      req[0] = 1'b1;
      tick();
      chk("reset_gnt", 32'(obs_g), 32'hFFFF_FFFF);
      chk("reset_rvalid", 32'(obs_rv[0]), 32'h0);
      mem_init = 1'b0;
      tick();
      reset = 1'b0;
      idle_all();

      // Single master read of 0x10.
      set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      tick();
      chk("t1_gnt", 32'(obs_g), 32'h0);
      idle_all();
      tick();
      chk("t1_rvalid", 32'(obs_rv[0]), 32'h1);
      chk("t1_rdata", obs_rd[0], 32'hDEADBEEF);
      chk("t1_m1_rvalid", 32'(obs_rv[1]), 32'h0);

      // Tie after reset alternates starting with m0.
      do_reset();
      set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("t2_tie_%0d", i), 32'(obs_g), 32'(tie_exp[i]));
      end
      idle_all();
      tick();

      // Lock with hold limit: four m0 grants, then m1 once.
      do_reset();
      set_m(0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
      set_m(1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("t3_lock_%0d", i), 32'(obs_g), 32'(lock_exp[i]));
      end
      idle_all();
      tick();

      // m1 writes 0x1234 to 0x20, m0 reads it back the next cycle.
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h1234);
      tick();
      chk("t4_wr_gnt", 32'(obs_g), 32'h1);
      idle_all();
      set_m(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      tick();
      chk("t4_rd_gnt", 32'(obs_g), 32'h0);
      chk("t4_no_wr_rvalid", 32'(obs_rv[1]), 32'h0);
      idle_all();
      tick();
      chk("t4_rvalid", 32'(obs_rv[0]), 32'h1);
      chk("t4_rdata", obs_rd[0], 32'h1234);
      chk("t4_m1_rvalid", 32'(obs_rv[1]), 32'h0);

      // m1 locked alone keeps the count at zero; m0 joins and waits four grants.
      set_m(1, 1'b1, 1'b0, 1'b1, 32'hC, 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t5_solo_%0d", i), 32'(obs_g), 32'h1);
      end
      set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (obs_g == 0) break;
         n++;
      end
      chk("t5_wait_grants", 32'(n), 32'h4);
      idle_all();
      tick();

      // Reset right after a read grant drops the read.
      set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      tick();
      chk("t6_gnt", 32'(obs_g), 32'h0);
      reset = 1'b1;
      idle_all();
      tick();
      chk("t6_rst_rvalid", 32'(obs_rv[0]), 32'h0);
      chk("t6_rst_rdata", obs_rd[0], 32'h0);
      reset = 1'b0;
      tick();
      chk("t6_after_rvalid", 32'(obs_rv[0]), 32'h0);
      set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      tick();
      chk("t6_tie_m0", 32'(obs_g), 32'h0);
      idle_all();
      tick();

`ifdef RAM_ARB_STATS_EN
      do_reset();
      set_m(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      for (int i = 0; i < 10; i++) tick();
      idle_all();
      tick();
      chk("stat_conflict", stat_conflict, 32'd10);
      chk("stat_gnt_sum", stat_gnt0 + stat_gnt1, 32'd10);
      chk("stat_gnt0", stat_gnt0, 32'd5);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
